// File: rtl/global_mem.sv
// Multi-port global memory: round-robin arbiter, one accept per cycle, and a
// fixed-latency response pipeline that returns ack/err/read data to the requester.
module global_mem #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 4096,
    parameter int LATENCY    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wr_data,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             rsp_ack,
    output logic [NUM_PORTS-1:0]             rsp_err,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rd_data
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [NUM_PORTS-1:0]  outstanding;
    logic [NUM_PORTS-1:0]  eligible;
    logic [PW-1:0]         last_grant;
    logic [PW-1:0]         grant_idx;
    logic                  grant_any;
    int                    cand;

    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wr_data;
    logic [DATA_WIDTH-1:0] acc_rd_data;
    logic                  acc_wr;
    logic                  acc_in_range;
    logic [MW-1:0]         mem_idx;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [LATENCY-1:0]    pipe_valid;
    logic [LATENCY-1:0]    pipe_err;
    logic [PW-1:0]         pipe_port [LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
    logic [DATA_WIDTH-1:0] hold_data [NUM_PORTS];

    // Handshake: a request transfers in the cycle where req_valid and req_ready
    // are both high; a port with a response in flight is eligible again only in
    // its own ack cycle, so each port has at most one outstanding request.
    always_comb begin
        eligible  = req_valid & (~outstanding | rsp_ack) & {NUM_PORTS{rst}};
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(last_grant) + i) % NUM_PORTS;
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = PW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_idx] = 1'b1;
    end

    assign acc_addr     = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign acc_wr_data  = req_wr_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign acc_wr       = req_wr[grant_idx];
    assign acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);
    assign mem_idx      = acc_addr[MW-1:0];
    assign acc_rd_data  = acc_in_range ? mem[mem_idx] : '0;

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (grant_any && acc_wr && acc_in_range) mem[mem_idx] <= acc_wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            last_grant  <= PW'(NUM_PORTS - 1);
            pipe_valid  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) hold_data[p] <= '0;
        end else begin
            outstanding <= (outstanding & ~rsp_ack) | req_ready;
            if (grant_any) last_grant <= grant_idx;
            pipe_valid[0] <= grant_any;
            for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rsp_ack[p]) hold_data[p] <= pipe_data[LATENCY-1];
            end
        end
    end

    // Payload rides alongside the valids; it is only observed when valid is set.
    always_ff @(posedge clk) begin
        pipe_port[0] <= grant_idx;
        pipe_err[0]  <= ~acc_in_range;
        pipe_data[0] <= acc_wr ? '0 : acc_rd_data;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_port[i] <= pipe_port[i-1];
            pipe_err[i]  <= pipe_err[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_comb begin
        rsp_ack     = '0;
        rsp_err     = '0;
        rsp_rd_data = '0;
        if (pipe_valid[LATENCY-1]) begin
            rsp_ack[pipe_port[LATENCY-1]] = 1'b1;
            rsp_err[pipe_port[LATENCY-1]] = pipe_err[LATENCY-1];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rsp_ack[p] ? pipe_data[LATENCY-1] : hold_data[p];
        end
    end

endmodule

// File: tb/tb_global_mem.sv
// Bench for global_mem: a LATENCY=4 and a LATENCY=1 instance, each checked every
// cycle against a transaction-level model (round-robin grants, memory map, response queue).
module tb_global_mem;

    localparam int NP    = 2;
    localparam int DEPTH = 4096;
    localparam int EW    = 42;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel = 1'b0;
    logic [1:0]  cur_valid = '0;
    logic [1:0]  cur_wr = '0;
    logic [31:0] cur_addr = '0;
    logic [63:0] cur_data = '0;
    int          tcyc = 0;

    logic [1:0]  v4, v1;
    logic [1:0]  ready4, ack4, err4, ready1, ack1, err1;
    logic [63:0] rd4, rd1;
    logic [1:0]  cur_ready, cur_ack, cur_err;
    logic [63:0] cur_rd;

    int checks = 0;
    int failures = 0;

    // model state
    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    logic [31:0]   mm [int];
    logic [1:0]    outs;
    int            lg;
    logic [31:0]   hold_data [2];
    logic [1:0]    hold_known;

    // observed event logs for directed literal checks
    int          grant_cyc_q[$];
    int          grant_port_q[$];
    int          ack_cyc_q[$];
    int          ack_port_q[$];
    logic [31:0] ack_data_q[$];
    logic        ack_err_q[$];

    assign v4 = sel ? 2'b00 : cur_valid;
    assign v1 = sel ? cur_valid : 2'b00;
    assign cur_ready = sel ? ready1 : ready4;
    assign cur_ack   = sel ? ack1 : ack4;
    assign cur_err   = sel ? err1 : err4;
    assign cur_rd    = sel ? rd1 : rd4;

    global_mem #(.NUM_PORTS(NP), .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(DEPTH), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .req_valid(v4), .req_wr(cur_wr), .req_addr(cur_addr),
        .req_wr_data(cur_data), .req_ready(ready4), .rsp_ack(ack4), .rsp_err(err4), .rsp_rd_data(rd4)
    );

    global_mem #(.NUM_PORTS(NP), .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_wr(cur_wr), .req_addr(cur_addr),
        .req_wr_data(cur_data), .req_ready(ready1), .rsp_ack(ack1), .rsp_err(err1), .rsp_rd_data(rd1)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // scoreboard / reference model, evaluated once per cycle on the falling edge
    initial begin
        logic [1:0]    e_ack, e_err, e_ready, elig;
        logic [EW-1:0] ent;
        logic          in_rng;
        int            ack_port, c, addr, lat;
        forever begin
            @(negedge clk);
            lat = sel ? 1 : 4;
            if (!rst) begin
                check("rst_ready", 64'(cur_ready), 64'(0));
                check("rst_ack", 64'(cur_ack), 64'(0));
                check("rst_err", 64'(cur_err), 64'(0));
                check("rst_rd_data", cur_rd, 64'(0));
                exp_q.delete();
                due_q.delete();
                outs = '0;
                lg = NP - 1;
                hold_data[0] = '0;
                hold_data[1] = '0;
                hold_known = 2'b11;
            end else begin
                e_ack = '0;
                e_err = '0;
                if (due_q.size() > 0 && due_q[0] == tcyc) begin
                    ent = exp_q.pop_front();
                    void'(due_q.pop_front());
                    ack_port = int'(ent[39:32]);
                    e_ack[ack_port] = 1'b1;
                    e_err[ack_port] = ent[40];
                    hold_data[ack_port] = ent[31:0];
                    hold_known[ack_port] = ent[41];
                end
                elig = cur_valid & (~outs | e_ack);
                e_ready = '0;
                for (int i = 1; i <= NP; i++) begin
                    c = (lg + i) % NP;
                    if (e_ready == 2'b00 && elig[c]) e_ready[c] = 1'b1;
                end
                check("req_ready", 64'(cur_ready), 64'(e_ready));
                check("rsp_ack", 64'(cur_ack), 64'(e_ack));
                check("rsp_err", 64'(cur_err), 64'(e_err));
                for (int p = 0; p < NP; p++) begin
                    if (hold_known[p]) check("rsp_rd_data", 64'(cur_rd[p*32 +: 32]), 64'(hold_data[p]));
                end
                for (int p = 0; p < NP; p++) begin
                    if (cur_ready[p]) begin
                        grant_cyc_q.push_back(tcyc);
                        grant_port_q.push_back(p);
                    end
                    if (cur_ack[p]) begin
                        ack_cyc_q.push_back(tcyc);
                        ack_port_q.push_back(p);
                        ack_data_q.push_back(cur_rd[p*32 +: 32]);
                        ack_err_q.push_back(cur_err[p]);
                    end
                end
                outs = outs & ~e_ack;
                if (e_ready != 2'b00) begin
                    c = e_ready[1] ? 1 : 0;
                    outs[c] = 1'b1;
                    lg = c;
                    addr = int'(cur_addr[c*16 +: 16]);
                    in_rng = (addr < DEPTH);
                    if (cur_wr[c]) begin
                        if (in_rng) mm[addr] = cur_data[c*32 +: 32];
                        ent = {1'b1, ~in_rng, 8'(c), 32'h0};
                    end else if (!in_rng) begin
                        ent = {1'b1, 1'b1, 8'(c), 32'h0};
                    end else if (mm.exists(addr)) begin
                        ent = {1'b1, 1'b0, 8'(c), mm[addr]};
                    end else begin
                        ent = {1'b0, 1'b0, 8'(c), 32'h0};
                    end
                    exp_q.push_back(ent);
                    due_q.push_back(tcyc + lat);
                end
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(n);
        rst = 1'b1;
    endtask

    task automatic clear_logs();
        grant_cyc_q.delete();
        grant_port_q.delete();
        ack_cyc_q.delete();
        ack_port_q.delete();
        ack_data_q.delete();
        ack_err_q.delete();
    endtask

    task automatic issue(input int p, input bit wr, input int addr, input logic [31:0] d, output int acc);
        int n;
        acc = -1;
        n = 0;
        cur_valid[p] = 1'b1;
        cur_wr[p] = wr;
        cur_addr[p*16 +: 16] = addr[15:0];
        cur_data[p*32 +: 32] = d;
        while (acc < 0 && n < 50) begin
            @(negedge clk);
            if (cur_ready[p]) acc = tcyc;
            n++;
        end
        check("issue_accepted", 64'(acc >= 0), 64'(1));
        @(posedge clk);
        #1;
        cur_valid[p] = 1'b0;
    endtask

    task automatic expect_ack(input string name, input int p, input int nth, input int exp_cyc,
                              input logic exp_err, input logic [31:0] exp_data);
        int idx, k;
        idx = -1;
        k = 0;
        for (int i = 0; i < ack_port_q.size(); i++) begin
            if (ack_port_q[i] == p) begin
                if (k == nth && idx < 0) idx = i;
                k++;
            end
        end
        check({name, "_found"}, 64'(idx >= 0), 64'(1));
        if (idx >= 0) begin
            check({name, "_cycle"}, 64'(ack_cyc_q[idx]), 64'(exp_cyc));
            check({name, "_err"}, 64'(ack_err_q[idx]), 64'(exp_err));
            check({name, "_data"}, 64'(ack_data_q[idx]), 64'(exp_data));
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            16: return 16'(DEPTH);
            17: return 16'(DEPTH + 1);
            18: return 16'hFFFF;
            19: return 16'(DEPTH - 1);
            default: return 16'(r);
        endcase
    endfunction

    task automatic rand_phase(input int n);
        logic [1:0] holding;
        holding = '0;
        repeat (n) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (cur_valid[p] && cur_ready[p]) holding[p] = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (!holding[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        cur_valid[p] = 1'b1;
                        cur_wr[p] = 1'($urandom_range(0, 1));
                        cur_addr[p*16 +: 16] = rand_addr();
                        cur_data[p*32 +: 32] = $urandom;
                        holding[p] = 1'b1;
                    end else begin
                        cur_valid[p] = 1'b0;
                    end
                end
            end
        end
        cur_valid = '0;
        idle(8);
    endtask

    // test sequence
    initial begin
        int a1, a2, a3, a4, r0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        cur_valid = 2'b11;
        idle(3);
        cur_valid = 2'b00;
        rst = 1'b1;

        // single port write then read, second request waits for the first ack
        clear_logs();
        issue(0, 1'b1, 5, 32'hDEADBEEF, a1);
        issue(0, 1'b0, 5, 32'h0, a2);
        idle(6);
        check("b2b_accept_in_ack_cycle", 64'(a2), 64'(a1 + 4));
        expect_ack("wr5", 0, 0, a1 + 4, 1'b0, 32'h0);
        expect_ack("rd5", 0, 1, a2 + 4, 1'b0, 32'hDEADBEEF);

        // contention: both ports continuously valid right after reset
        do_reset(2);
        clear_logs();
        r0 = tcyc;
        cur_wr = 2'b00;
        cur_addr = {16'd5, 16'd5};
        cur_valid = 2'b11;
        idle(16);
        cur_valid = 2'b00;
        idle(6);
        check("cont_ngrants", 64'(grant_cyc_q.size() >= 4), 64'(1));
        if (grant_cyc_q.size() >= 4) begin
            check("cont_g0_cycle", 64'(grant_cyc_q[0]), 64'(r0));
            check("cont_g0_port", 64'(grant_port_q[0]), 64'(0));
            check("cont_g1_cycle", 64'(grant_cyc_q[1]), 64'(r0 + 1));
            check("cont_g1_port", 64'(grant_port_q[1]), 64'(1));
            check("cont_g2_cycle", 64'(grant_cyc_q[2]), 64'(r0 + 4));
            check("cont_g2_port", 64'(grant_port_q[2]), 64'(0));
            check("cont_g3_cycle", 64'(grant_cyc_q[3]), 64'(r0 + 5));
            check("cont_g3_port", 64'(grant_port_q[3]), 64'(1));
        end
        expect_ack("cont_ack_p0", 0, 0, r0 + 4, 1'b0, 32'hDEADBEEF);
        expect_ack("cont_ack_p1", 1, 0, r0 + 5, 1'b0, 32'hDEADBEEF);

        // out of range at addr = DEPTH, and addr 0 unaffected
        clear_logs();
        issue(1, 1'b1, 0, 32'h12345678, a1);
        issue(0, 1'b1, DEPTH, 32'hAAAA5555, a2);
        issue(0, 1'b0, DEPTH, 32'h0, a3);
        issue(1, 1'b0, 0, 32'h0, a4);
        idle(8);
        expect_ack("oor_wr", 0, 0, a2 + 4, 1'b1, 32'h0);
        expect_ack("oor_rd", 0, 1, a3 + 4, 1'b1, 32'h0);
        expect_ack("addr0_rd", 1, 1, a4 + 4, 1'b0, 32'h12345678);

        // reset while a read is in flight
        issue(1, 1'b1, 7, 32'hCAFEF00D, a1);
        idle(6);
        clear_logs();
        issue(0, 1'b0, 7, 32'h0, a1);
        idle(1);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(8);
        check("midreset_no_ack", 64'(ack_cyc_q.size()), 64'(0));
        clear_logs();
        issue(0, 1'b0, 7, 32'h0, a2);
        idle(6);
        expect_ack("post_reset_rd7", 0, 0, a2 + 4, 1'b0, 32'hCAFEF00D);

        rand_phase(300);

        // LATENCY=1 instance: RAW across ports
        sel = 1'b1;
        mm.delete();
        do_reset(2);
        clear_logs();
        issue(0, 1'b1, 3, 32'h0BADF00D, a1);
        issue(1, 1'b0, 3, 32'h0, a2);
        idle(4);
        check("l1_rd_accept", 64'(a2), 64'(a1 + 1));
        expect_ack("l1_wr", 0, 0, a1 + 1, 1'b0, 32'h0);
        expect_ack("l1_raw_rd", 1, 0, a2 + 1, 1'b0, 32'h0BADF00D);

        rand_phase(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
